// File: rtl/gram_array_ctrl.sv
// Job sequencer for a ROWS x ROWS Gram-product systolic array: operand reads, skewed diagonal enables, capture strobes.
// Latency: reads begin the cycle after start, done follows DIMENSION+2*ROWS cycles later; no backpressure, abort/rst flush at once.
module gram_array_ctrl #(
    parameter int WIDTH     = 8,
    parameter int DIMENSION = 256,
    parameter int ROWS      = 4,
    parameter int ADDR_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic                     rd_en,
    output logic [ADDR_W-1:0]        rd_addr,
    output logic [2*ROWS-2:0]        en_diag,
    output logic                     diag_valid,
    output logic [((2*ROWS-1) > 1 ? $clog2(2*ROWS-1) : 1)-1:0] diag_idx
);

    localparam int NDIAG = 2*ROWS - 1;
    localparam int IDX_W = (NDIAG > 1) ? $clog2(NDIAG) : 1;
    localparam int CNT_W = ADDR_W + 1;
    localparam int DR_W  = $clog2(2*ROWS);

    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(DIMENSION - 1);
    localparam logic [DR_W-1:0]  DR_LAST = DR_W'(2*ROWS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FEED  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    if (((1 << ADDR_W) < DIMENSION) || (ROWS < 1) || (WIDTH < 1)) begin : g_param_check
        $error("gram_array_ctrl: illegal parameter combination");
    end

    logic [1:0]       state;
    logic [CNT_W-1:0] rd_cnt;
    logic [DR_W-1:0]  dr_cnt;
    logic [NDIAG-1:0] skew;
    logic [NDIAG-1:0] skew_in;
    logic [NDIAG-1:0] fall;
    logic [IDX_W-1:0] fall_idx;

    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);
    assign rd_en   = (state == S_FEED);
    assign rd_addr = rd_en ? rd_cnt[ADDR_W-1:0] : '0;
    assign en_diag = skew;

    // Stage 0 follows rd_en one cycle late to match the buffer read latency;
    // each further diagonal is one more cycle behind its predecessor.
    assign skew_in = NDIAG'({skew, rd_en});

    // A diagonal's final products are valid in the first cycle after its enable drops.
    assign fall = skew & ~skew_in;

    always_comb begin
        fall_idx = '0;
        for (int d = 0; d < NDIAG; d++) begin
            if (fall[d]) begin
                fall_idx = IDX_W'(d);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            rd_cnt     <= '0;
            dr_cnt     <= '0;
            skew       <= '0;
            diag_valid <= 1'b0;
            diag_idx   <= '0;
        end else if (abort && (state != S_IDLE)) begin
            state      <= S_IDLE;
            rd_cnt     <= '0;
            dr_cnt     <= '0;
            skew       <= '0;
            diag_valid <= 1'b0;
        end else begin
            skew       <= skew_in;
            diag_valid <= |fall;
            if (|fall) begin
                diag_idx <= fall_idx;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_FEED;
                        rd_cnt <= '0;
                    end
                end
                S_FEED: begin
                    if (rd_cnt == RD_LAST) begin
                        state  <= S_DRAIN;
                        rd_cnt <= '0;
                        dr_cnt <= '0;
                    end else begin
                        rd_cnt <= rd_cnt + CNT_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (dr_cnt == DR_LAST) begin
                        state  <= S_DONE;
                        dr_cnt <= '0;
                    end else begin
                        dr_cnt <= dr_cnt + DR_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gram_array_ctrl.sv
// Bench for gram_array_ctrl at default parameters: directed job/abort/reset scenarios, then random traffic vs a job-timeline model.
module tb_gram_array_ctrl;

    localparam int D      = 256;
    localparam int R      = 4;
    localparam int ND     = 2*R - 1;
    localparam int ADDR_W = 8;
    localparam int LAST_K = D + 2*R + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [ND-1:0]     en_diag;
    logic              diag_valid;
    logic [2:0]        diag_idx;

    int checks = 0;
    int errors = 0;

    // Model: job_k is the cycle number within the current job (-1 when idle).
    int         job_k = -1;
    logic [2:0] idx_exp = 3'd0;
    bit         idx_after_rst = 1'b0;

    int cnt_rd = 0;
    int cnt_en0 = 0;
    int cnt_dv = 0;
    int cnt_done = 0;

    gram_array_ctrl #(
        .WIDTH(8),
        .DIMENSION(D),
        .ROWS(R),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .abort(abort),
        .busy(busy),
        .done(done),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .en_diag(en_diag),
        .diag_valid(diag_valid),
        .diag_idx(diag_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s k=%0d got %0h expected %0h", tag, job_k, got, exp);
        end
    endtask

    task automatic check_outputs();
        logic          e_rd;
        logic [7:0]    e_addr;
        logic [ND-1:0] e_en;
        logic          e_dv;
        int            k;
        k      = job_k;
        e_rd   = (k >= 1) && (k <= D);
        e_addr = e_rd ? 8'(k - 1) : 8'd0;
        for (int d = 0; d < ND; d++) begin
            e_en[d] = (k >= 2 + d) && (k <= D + 1 + d);
        end
        e_dv = (k >= D + 2) && (k <= D + 2*R);
        if (e_dv) idx_exp = 3'(k - D - 2);
        chk("busy", 32'(busy), 32'((k >= 1) && (k <= LAST_K)));
        chk("done", 32'(done), 32'(k == LAST_K));
        chk("rd_en", 32'(rd_en), 32'(e_rd));
        chk("rd_addr", 32'(rd_addr), 32'(e_addr));
        chk("en_diag", 32'(en_diag), 32'(e_en));
        chk("diag_valid", 32'(diag_valid), 32'(e_dv));
        if (e_dv || idx_after_rst) begin
            chk("diag_idx", 32'(diag_idx), 32'(idx_exp));
        end
        idx_after_rst = 1'b0;
        if (rd_en === 1'b1)      cnt_rd++;
        if (en_diag[0] === 1'b1) cnt_en0++;
        if (diag_valid === 1'b1) cnt_dv++;
        if (done === 1'b1)       cnt_done++;
    endtask

    // One clock: drive inputs, advance the model at the edge, check mid-cycle.
    task automatic cycle(input bit s, input bit a, input bit r);
        start = s;
        abort = a;
        rst   = r;
        @(posedge clk);
        if (!r) begin
            job_k         = -1;
            idx_exp       = 3'd0;
            idx_after_rst = 1'b1;
        end else if (job_k < 0) begin
            if (s) job_k = 1;
        end else if (a || (job_k == LAST_K)) begin
            job_k = -1;
        end else begin
            job_k++;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic clear_counts();
        cnt_rd   = 0;
        cnt_en0  = 0;
        cnt_dv   = 0;
        cnt_done = 0;
    endtask

    initial begin
        repeat (3) cycle(0, 0, 0);
        repeat (2) cycle(0, 0, 1);

        // Clean job: full read sweep to address 255, full wavefront, single done.
        clear_counts();
        cycle(1, 0, 1);
        repeat (LAST_K + 5) cycle(0, 0, 1);
        chk("clean_rd_cycles", 32'(cnt_rd), 32'(D));
        chk("clean_en0_cycles", 32'(cnt_en0), 32'(D));
        chk("clean_dv_cycles", 32'(cnt_dv), 32'(ND));
        chk("clean_done_count", 32'(cnt_done), 32'd1);

        // Abort at cycle 5 of a job, then restart with full timing.
        clear_counts();
        cycle(1, 0, 1);
        repeat (4) cycle(0, 0, 1);
        cycle(0, 1, 1);
        repeat (3) cycle(0, 0, 1);
        chk("abort_no_done", 32'(cnt_done), 32'd0);
        chk("abort_no_dv", 32'(cnt_dv), 32'd0);
        cycle(1, 0, 1);
        repeat (LAST_K + 2) cycle(0, 0, 1);

        // Abort during drain, and abort during the done cycle.
        cycle(1, 0, 1);
        repeat (D + 3) cycle(0, 0, 1);
        cycle(0, 1, 1);
        repeat (3) cycle(0, 0, 1);
        cycle(1, 0, 1);
        repeat (LAST_K - 1) cycle(0, 0, 1);
        cycle(0, 1, 1);
        repeat (3) cycle(0, 0, 1);

        // Start and abort together while idle: start wins.
        cycle(1, 1, 1);
        repeat (LAST_K + 2) cycle(0, 0, 1);

        // Reset mid-job at cycle 12.
        cycle(1, 0, 1);
        repeat (11) cycle(0, 0, 1);
        cycle(0, 0, 0);
        repeat (4) cycle(0, 0, 1);

        // Start held high: three back-to-back jobs of unchanged length.
        clear_counts();
        repeat (3 * (LAST_K + 1)) cycle(1, 0, 1);
        chk("held_start_done_count", 32'(cnt_done), 32'd3);
        chk("held_start_rd_cycles", 32'(cnt_rd), 32'(3 * D));
        repeat (4) cycle(0, 0, 1);

        // Random traffic with occasional abort and reset.
        for (int n = 0; n < 8000; n++) begin
            cycle(($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 399) == 0),
                  ($urandom_range(0, 1499) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
